// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizer, clock glitch filter, frame FSM
// with parity/stop/timeout checks, and a small scan-code FIFO with read handshake.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 14000,
  parameter int FIFO_AW        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_scan_code,
  output logic       rx_data_ready,
  input  logic       rx_read,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int FW    = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          filt_level, fe;
  logic [FW-1:0] filt_cnt;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          push_req;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_next;
  logic               pop_ok, push_ok;

  // Two-flop synchronizers, reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  // Clock glitch filter: level flips only after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
      fe         <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_sync == filt_level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_level <= clk_sync;
        filt_cnt   <= '0;
        fe         <= filt_level;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM; shreg stays stable after STOP so it doubles as the push data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      par_bit       <= 1'b0;
      tmo_cnt       <= '0;
      push_req      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      push_req      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      if (state == IDLE || fe) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state != IDLE && !fe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        rx_frame_err <= 1'b1;
        state        <= IDLE;
      end else if (fe) begin
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end
          DATA: begin
            shreg[bit_cnt] <= data_sync;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            par_bit <= data_sync;
            state   <= STOP;
          end
          STOP: begin
            if (!data_sync) begin
              rx_frame_err <= 1'b1;
            end else if (odd_parity_ok(shreg, par_bit)) begin
              push_req <= 1'b1;
            end else begin
              rx_parity_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else begin
        state <= state;
      end
    end
  end

  // A pop on an empty FIFO is ignored; a full FIFO may still accept a push if a pop lands alongside.
  always_comb begin
    pop_ok     = rx_read && (count != '0);
    push_ok    = push_req && ((count < CW'(DEPTH)) || pop_ok);
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers, count, registered read data, ready and overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rx_scan_code  <= 8'h00;
      rx_data_ready <= 1'b0;
      rx_overflow   <= 1'b0;
    end else begin
      rx_overflow   <= push_req && !push_ok;
      count         <= count_next;
      rx_data_ready <= (count_next != '0);
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr       <= rd_ptr + 1'b1;
        rx_scan_code <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized bench for ps2_rx_fifo against a queue-based model of
// frame acceptance, error pulses and FIFO ordering.
module tb_ps2_rx_fifo;

  localparam int H     = 25;
  localparam int TMO   = 14000;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_scan_code;
  logic       rx_data_ready, rx_parity_err, rx_frame_err, rx_overflow;

  ps2_rx_fifo dut (
    .clk(clk), .reset(reset), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .rx_scan_code(rx_scan_code), .rx_data_ready(rx_data_ready), .rx_read(rx_read),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_par = 0, n_frm = 0, n_ovf = 0;
  int exp_par = 0, exp_frm = 0, exp_ovf = 0;
  logic [7:0] q[$];
  logic [7:0] last_code = 8'h00;

  // Count cycles each pulse output is high; a stuck pulse shows up as an excess.
  always @(posedge clk) begin
    if (rx_parity_err) n_par++;
    if (rx_frame_err) n_frm++;
    if (rx_overflow) n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data_i = fr[i];
      repeat (H) @(negedge clk);
      ps2_clk_i = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk_i = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps2_data_i = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop) exp_frm++;
    else if (bad_par) exp_par++;
    else if (q.size() < DEPTH) q.push_back(b);
    else exp_ovf++;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    model_frame(b, bad_par, bad_stop);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".ready"}, 32'(rx_data_ready), 32'(q.size() != 0));
    check({tag, ".par"}, n_par, exp_par);
    check({tag, ".frm"}, n_frm, exp_frm);
    check({tag, ".ovf"}, n_ovf, exp_ovf);
  endtask

  task automatic read_check(input string tag);
    @(negedge clk) rx_read = 1'b1;
    @(negedge clk) rx_read = 1'b0;
    if (q.size() > 0) last_code = q.pop_front();
    check({tag, ".code"}, 32'(rx_scan_code), 32'(last_code));
    check({tag, ".ready"}, 32'(rx_data_ready), 32'(q.size() != 0));
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    ps2_data_i = 1'b0;
    ps2_clk_i  = 1'b0;
    repeat (len) @(negedge clk);
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    logic [10:0] fr;
    logic [7:0]  b;
    bit bp, bs;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("rst.code", 32'(rx_scan_code), 32'h00);
    check("rst.ready", 32'(rx_data_ready), 32'h0);
    check("rst.pulses", 32'({rx_parity_err, rx_frame_err, rx_overflow}), 32'h0);

    // Single good frame
    send_frame(8'h1C, 1'b0, 1'b0);
    check_status("f1c");
    read_check("f1c.rd");

    // Prefix burst with no reads, then spaced reads
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_status("burst");
    for (int i = 0; i < 3; i++) begin
      read_check($sformatf("burst.rd%0d", i));
      @(negedge clk);
    end

    // Parity and stop-bit errors
    send_frame(8'h1C, 1'b1, 1'b0);
    check_status("badpar");
    send_frame(8'h1C, 1'b0, 1'b1);
    check_status("badstop");

    // Sub-threshold glitches must not start a frame that would corrupt the next one
    glitch(1);
    glitch(7);
    check_status("glitch");
    b = 8'($urandom);
    send_frame(b, 1'b0, 1'b0);
    check_status("postglitch");
    read_check("postglitch.rd");

    // Stalled frame: no error just before the timeout, exactly one after
    b = 8'($urandom);
    send_bits(make_frame(b, 1'b0, 1'b0), 4);
    repeat (TMO - 200) @(negedge clk);
    check("tmo.early", n_frm, exp_frm);
    repeat (400) @(negedge clk);
    exp_frm++;
    check_status("tmo");
    send_frame(8'h29, 1'b0, 1'b0);
    check_status("f29");
    read_check("f29.rd");

    // Overflow on the ninth byte
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_status("ovf");
    for (int i = 0; i < DEPTH; i++) read_check($sformatf("ovf.rd%0d", i));
    read_check("empty.rd");

    // Ninth push coincident with a pop: accepted, no overflow
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
    fr = make_frame(8'h09, 1'b0, 1'b0);
    send_bits(fr, 10);
    @(negedge clk) ps2_data_i = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk_i = 1'b0;
    repeat (11) @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk) rx_read = 1'b0;
    last_code = q.pop_front();
    model_frame(8'h09, 1'b0, 1'b0);
    repeat (H) @(negedge clk);
    ps2_clk_i = 1'b1;
    repeat (H + 20) @(negedge clk);
    check("coinc.code", 32'(rx_scan_code), 32'(last_code));
    check_status("coinc");
    for (int i = 0; i < DEPTH; i++) read_check($sformatf("coinc.rd%0d", i));

    // Randomized frames with occasional errors and reads
    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 7) == 0);
      send_frame(b, bp, bs);
      check_status($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) read_check($sformatf("rnd%0d.rd", i));
    end
    while (q.size() > 0) read_check("rnd.drain");

    // Reset mid-frame with two bytes queued
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0);
    b = 8'($urandom);
    send_bits(make_frame(b, 1'b0, 1'b0), 4);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    q.delete();
    last_code = 8'h00;
    check("midrst.code", 32'(rx_scan_code), 32'h00);
    check_status("midrst");
    send_frame(8'h5A, 1'b0, 1'b0);
    check_status("afterrst");
    read_check("afterrst.rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver with a glitch filter, frame state machine, parity/framing checks, an inactivity timeout and a small scan-code FIFO. It sits directly upstream of the ZX keyboard matrix decoder and feeds it raw scan-code bytes (including 0xE0/0xF0 prefixes) through a ready/read handshake. Buffering lets the decoder's multi-cycle state machine fall behind during fast bursts without losing bytes.

## Interface
- FILTER_LEN, 8: consecutive equal synchronized samples required to change the filtered ps2_clk level (≥2).
- TIMEOUT_CYCLES, 14000: clk cycles without a filtered falling edge mid-frame before the frame is aborted (~1 ms at 14 MHz).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock, ≥14 MHz.
- reset  in  1  reset reset, synchronous, active-high; clock clk.
- ps2_clk_i  in  1  raw PS/2 clock, asynchronous.
- ps2_data_i  in  1  raw PS/2 data, asynchronous.
- rx_scan_code  out  8  registered byte popped by the last accepted rx_read.
- rx_data_ready  out  1  FIFO not empty.
- rx_read  in  1  one-cycle pop request.
- rx_parity_err  out  1  one-cycle pulse: frame dropped, parity wrong.
- rx_frame_err  out  1  one-cycle pulse: frame dropped, bad stop bit or timeout.
- rx_overflow  out  1  one-cycle pulse: good byte dropped, FIFO full.

## Operation
- Input path: ps2_clk_i and ps2_data_i each pass a 2-FF synchronizer. Clock then goes through the filter: counter reloads on disagreement and the filtered level flips after FILTER_LEN agreeing samples. Falling edge = filtered level 1→0, one-cycle strobe `fe`.
- Frame FSM, bits sampled from synchronized data on `fe`:
  - IDLE: on `fe` with data=0 (start) → DATA, bit count 0. On `fe` with data=1, stay IDLE (spurious).
  - DATA: shift data into bit[count], LSB first; after 8th bit → PARITY.
  - PARITY: capture bit → STOP.
  - STOP: on `fe`: data=1 and odd parity over 9 bits → push byte; data=1 and parity bad → rx_parity_err; data=0 → rx_frame_err. Always → IDLE.
  - Any non-IDLE state: inactivity counter resets on every `fe`; reaching TIMEOUT_CYCLES → rx_frame_err, → IDLE, partial byte discarded.
- FIFO: 2**FIFO_AW × 8, wrap-around pointers, count width FIFO_AW+1.
  - Push when count < depth, or when full and a pop is accepted in the same cycle (count unchanged). Otherwise drop and pulse rx_overflow.
  - rx_read with count 0 is ignored; rx_scan_code holds its value.
  - Simultaneous push and pop when empty: pop ignored, push accepted.
- No byte interpretation; prefixes and codes pass through unchanged.

## Timing
- Reset values: rx_scan_code 0x00, rx_data_ready 0, all error pulses 0, FSM IDLE, FIFO empty, filter level 1, inactivity counter 0.
- Reset mid-frame aborts the frame without an error pulse; FIFO contents are lost.
- Filtered edge lags raw ps2_clk fall by 2 (sync) + FILTER_LEN cycles.
- Push occurs on the cycle after the stop-bit `fe`. rx_data_ready rises on the following cycle; it is a registered function of count.
- Read handshake: consumer drives rx_read high for one cycle (edge N). rx_scan_code holds the popped byte from edge N onward and is valid when the consumer samples at edge N+1. rx_data_ready reflects the new count after edge N.
- A read on every cycle drains one byte per cycle. Back-to-back reads are legal.
- Error pulses assert for exactly one cycle, on the cycle after the offending `fe` or timeout.

## Test plan
- Single frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 12 kHz PS/2 clock → rx_data_ready=1; rx_read pulse → rx_scan_code=0x1C next cycle, rx_data_ready=0.
- Burst E0, F0, 75 with no reads → three FIFO entries; three rx_read pulses two cycles apart → rx_scan_code 0xE0, 0xF0, 0x75 in order.
- Frame 0x1C with parity 1 → rx_parity_err single pulse, rx_data_ready stays 0. Stop bit 0 → rx_frame_err, no push.
- 1-cycle and (FILTER_LEN−1)-cycle low glitches on ps2_clk while idle → no `fe`, no errors. Start bit plus 3 bits then stall for TIMEOUT_CYCLES → rx_frame_err. A following valid 0x29 frame is received correctly.
- Send 9 frames 0x01…0x09 with FIFO_AW=3 and no reads → rx_overflow once on the 9th, reads return 0x01…0x08. Repeat the full case with rx_read coincident with the 9th push → 0x09 accepted, no overflow.
- Assert reset during DATA of a frame with 2 bytes queued → rx_data_ready=0 and rx_scan_code=0x00 next cycle, no error pulses. The next complete frame is received.
